dp_control_unit: RTL and testbench

Multi-cycle control unit for the 16-bit datapath (pc, reg_group, alu_mux, alu). It fetches the instruction addressed by pc_out from a synchronous instruction ROM and decodes it. It then sequences the datapath's enable chain and registers write-back and PC update. A WAIT-state watchdog catches a datapath that never returns its completion strobe.

---
 rtl/dp_ctrl_pkg.sv | 50 +++++
 rtl/dp_ctrl_decode.sv | 33 +++
 rtl/dp_control_unit.sv | 144 ++++++++++++++
 tb/tb_dp_control_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dp_ctrl_pkg.sv
// Shared opcode, ALU-function, PC-control and state encodings for the datapath control unit.
package dp_ctrl_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0, OP_MOV = 4'h1, OP_MVI = 4'h2, OP_ADD = 4'h3,
                         OP_SUB  = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_ADI = 4'h7,
                         OP_SHL  = 4'h8, OP_SHR = 4'h9, OP_JMP = 4'hA, OP_JR  = 4'hB,
                         OP_HALT = 4'hF;

  localparam logic [2:0] ALU_MOV = 3'b000, ALU_ADD = 3'b001, ALU_SUB = 3'b010,
                         ALU_AND = 3'b011, ALU_OR  = 3'b100, ALU_SHL = 3'b101,
                         ALU_SHR = 3'b110;

  localparam logic [1:0] PC_HOLD = 2'b00, PC_INC = 2'b01, PC_ABS = 2'b10, PC_REL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_PCUPD, S_HALT
  } state_t;

  typedef enum logic [2:0] {CLS_NOP, CLS_ALU, CLS_JMP, CLS_HALT, CLS_ILL} cls_t;

  typedef struct packed {
    cls_t       cls;
    logic [2:0] alu_func;
    logic       alu_in_sel;
    logic [1:0] pc_ctrl;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
  } dec_t;

  // Every registered output of the control unit, cleared as one on reset.
  typedef struct packed {
    logic       en_pc_pulse;
    logic [1:0] pc_ctrl;
    logic [7:0] offset_addr;
    logic [7:0] offset;
    logic       en_in;
    logic [3:0] reg_en;
    logic       alu_in_sel;
    logic [2:0] alu_func;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       halted;
    logic       err_timeout;
    logic       illegal;
  } ctl_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction
endpackage

// File: rtl/dp_ctrl_decode.sv
// Combinational instruction decoder: splits the IR into fields and classifies the opcode.
module dp_ctrl_decode
  import dp_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);
  always_comb begin
    dec            = '0;
    dec.cls        = CLS_ALU;
    dec.pc_ctrl    = PC_INC;
    dec.rd         = ir[11:10];
    dec.rs         = ir[9:8];
    dec.imm        = ir[7:0];
    case (ir[15:12])
      OP_NOP:  dec.cls = CLS_NOP;
      OP_MOV:  dec.alu_func = ALU_MOV;
      OP_MVI:  begin dec.alu_func = ALU_MOV; dec.alu_in_sel = 1'b1; end
      OP_ADD:  dec.alu_func = ALU_ADD;
      OP_SUB:  dec.alu_func = ALU_SUB;
      OP_AND:  dec.alu_func = ALU_AND;
      OP_OR:   dec.alu_func = ALU_OR;
      OP_ADI:  begin dec.alu_func = ALU_ADD; dec.alu_in_sel = 1'b1; end
      OP_SHL:  dec.alu_func = ALU_SHL;
      OP_SHR:  dec.alu_func = ALU_SHR;
      OP_JMP:  begin dec.cls = CLS_JMP; dec.pc_ctrl = PC_ABS; end
      OP_JR:   begin dec.cls = CLS_JMP; dec.pc_ctrl = PC_REL; end
      OP_HALT: dec.cls = CLS_HALT;
      // undefined opcodes advance the PC like a NOP
      default: dec.cls = CLS_ILL;
    endcase
  end
endmodule

// File: rtl/dp_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit datapath with a WAIT watchdog.
module dp_control_unit
  import dp_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ROM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic        dp_done,
  output logic        en_pc_pulse,
  output logic [1:0]  pc_ctrl,
  output logic [7:0]  offset_addr,
  output logic [7:0]  offset,
  output logic        en_in,
  output logic [3:0]  reg_en,
  output logic        alu_in_sel,
  output logic [2:0]  alu_func,
  output logic [1:0]  rd,
  output logic [1:0]  rs,
  output logic        halted,
  output logic        err_timeout,
  output logic        illegal
);
  localparam logic [7:0] FETCH_LD  = 8'(ROM_LAT - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] ir_q, ir_n;
  ctl_t        q, d;
  dec_t        dec;

  dp_ctrl_decode u_dec (.ir(ir_q), .dec(dec));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      ir_q  <= '0;
      q     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ir_q  <= ir_n;
      q     <= d;
    end
  end

  // Outputs are computed for the state being entered, so each strobe is
  // registered and lines up with the cycle spent in that state.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    ir_n          = ir_q;
    d             = q;
    d.en_pc_pulse = 1'b0;
    d.pc_ctrl     = PC_HOLD;
    d.en_in       = 1'b0;
    d.reg_en      = '0;
    d.illegal     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          cnt_n   = FETCH_LD;
        end
      end
      S_FETCH: begin
        if (cnt == '0) begin
          ir_n    = ir;
          state_n = S_DECODE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_DECODE: begin
        d.rd          = dec.rd;
        d.rs          = dec.rs;
        d.offset      = dec.imm;
        d.offset_addr = dec.imm;
        d.alu_func    = dec.alu_func;
        d.alu_in_sel  = dec.alu_in_sel;
        case (dec.cls)
          CLS_ALU: begin
            state_n = S_EXEC;
            d.en_in = 1'b1;
          end
          CLS_HALT: begin
            state_n  = S_HALT;
            d.halted = 1'b1;
          end
          default: begin
            state_n       = S_PCUPD;
            d.en_pc_pulse = 1'b1;
            d.pc_ctrl     = dec.pc_ctrl;
            d.illegal     = (dec.cls == CLS_ILL);
          end
        endcase
      end
      S_EXEC: begin
        state_n = S_WAIT;
        cnt_n   = '0;
      end
      S_WAIT: begin
        // a completion on the last watchdog cycle still wins
        if (dp_done) begin
          state_n       = S_WB;
          d.reg_en      = onehot4(q.rd);
          d.en_pc_pulse = 1'b1;
          d.pc_ctrl     = PC_INC;
        end else if (cnt == WAIT_LAST) begin
          state_n       = S_HALT;
          d.halted      = 1'b1;
          d.err_timeout = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_WB, S_PCUPD: begin
        state_n = S_FETCH;
        cnt_n   = FETCH_LD;
      end
      S_HALT:  d.halted = 1'b1;
      default: state_n = S_IDLE;
    endcase
  end

  assign en_pc_pulse = q.en_pc_pulse;
  assign pc_ctrl     = q.pc_ctrl;
  assign offset_addr = q.offset_addr;
  assign offset      = q.offset;
  assign en_in       = q.en_in;
  assign reg_en      = q.reg_en;
  assign alu_in_sel  = q.alu_in_sel;
  assign alu_func    = q.alu_func;
  assign rd          = q.rd;
  assign rs          = q.rs;
  assign halted      = q.halted;
  assign err_timeout = q.err_timeout;
  assign illegal     = q.illegal;
endmodule

// File: tb/tb_dp_control_unit.sv
// Directed, table-driven bench for dp_control_unit (TIMEOUT=16, ROM_LAT=1).
module tb_dp_control_unit;
  logic        clk = 1'b0;
  logic        rst, start, dp_done;
  logic [15:0] ir;
  logic        en_pc_pulse, en_in, alu_in_sel, halted, err_timeout, illegal;
  logic [1:0]  pc_ctrl, rd, rs;
  logic [7:0]  offset_addr, offset;
  logic [3:0]  reg_en;
  logic [2:0]  alu_func;

  dp_control_unit #(.TIMEOUT(16), .ROM_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir), .dp_done(dp_done),
    .en_pc_pulse(en_pc_pulse), .pc_ctrl(pc_ctrl), .offset_addr(offset_addr),
    .offset(offset), .en_in(en_in), .reg_en(reg_en), .alu_in_sel(alu_in_sel),
    .alu_func(alu_func), .rd(rd), .rs(rs), .halted(halted),
    .err_timeout(err_timeout), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    int          k;      // WAIT cycle in which dp_done arrives, 0 = never
    int          lat;    // negedges from previous PC strobe to this one
    logic        pulse;
    logic [1:0]  pc;
    logic [3:0]  reg_en;
    logic        is_alu;
    logic [2:0]  func;
    logic        sel;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  imm;
    int          n_ill;
    int          n_en;
    logic        halt;
    logic        err;
  } vec_t;

  vec_t tab[$];
  int   n_vec = 0, n_bad = 0;
  int   dp_k  = 1;

  function automatic vec_t mk(input logic [15:0] i, input int k, input int lat,
                              input logic pulse, input logic [1:0] pc, input logic [3:0] re,
                              input logic alu, input logic [2:0] fn, input logic sl,
                              input logic [1:0] d_rd, input logic [1:0] d_rs,
                              input logic [7:0] imm, input int nill, input int nen,
                              input logic hl, input logic er);
    vec_t v;
    v.ir = i; v.k = k; v.lat = lat; v.pulse = pulse; v.pc = pc; v.reg_en = re;
    v.is_alu = alu; v.func = fn; v.sel = sl; v.rd = d_rd; v.rs = d_rs; v.imm = imm;
    v.n_ill = nill; v.n_en = nen; v.halt = hl; v.err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [34:0] all_out();
    return {en_pc_pulse, pc_ctrl, offset_addr, offset, en_in, reg_en, alu_in_sel,
            alu_func, rd, rs, halted, err_timeout, illegal};
  endfunction

  // Datapath model: completion strobe in the k-th WAIT cycle after en_in.
  initial begin
    dp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (en_in && dp_k > 0) begin
        repeat (dp_k) @(negedge clk);
        dp_done = 1'b1;
        @(negedge clk);
        dp_done = 1'b0;
      end
    end
  end

  // Called at the negedge of the previous PC strobe (or just after reset release).
  task automatic run_vec(input int idx);
    vec_t       v;
    int         cyc, nen, nill, ovl;
    logic [3:0] rseen;
    v = tab[idx];
    cyc = 0; nen = 0; nill = 0; ovl = 0; rseen = '0;
    dp_k = v.k;
    ir   = v.ir;
    do begin
      @(negedge clk);
      cyc++;
      if (en_in) nen++;
      if (illegal) nill++;
      rseen |= reg_en;
      if ((en_in && (en_pc_pulse || reg_en != 4'b0)) || (reg_en != 4'b0 && !en_pc_pulse)) ovl++;
    end while (!en_pc_pulse && !halted && cyc < 60);
    chk($sformatf("v%0d latency", idx), cyc, v.lat);
    chk($sformatf("v%0d en_pc_pulse", idx), en_pc_pulse, v.pulse);
    if (v.pulse) chk($sformatf("v%0d pc_ctrl", idx), pc_ctrl, v.pc);
    chk($sformatf("v%0d reg_en", idx), reg_en, v.reg_en);
    chk($sformatf("v%0d reg_en_seen", idx), rseen, v.reg_en);
    chk($sformatf("v%0d rd", idx), rd, v.rd);
    chk($sformatf("v%0d rs", idx), rs, v.rs);
    chk($sformatf("v%0d offset", idx), offset, v.imm);
    chk($sformatf("v%0d offset_addr", idx), offset_addr, v.imm);
    if (v.is_alu) begin
      chk($sformatf("v%0d alu_func", idx), alu_func, v.func);
      chk($sformatf("v%0d alu_in_sel", idx), alu_in_sel, v.sel);
    end
    chk($sformatf("v%0d illegal_cnt", idx), nill, v.n_ill);
    chk($sformatf("v%0d en_in_cnt", idx), nen, v.n_en);
    chk($sformatf("v%0d strobe_overlap", idx), ovl, 0);
    chk($sformatf("v%0d halted", idx), halted, v.halt);
    chk($sformatf("v%0d err_timeout", idx), err_timeout, v.err);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    int seen, bad;
    //            ir        k  lat pl pc     reg_en  alu fn      sel rd rs imm    il en hl er
    tab.push_back(mk(16'h0000, 1, 3, 1, 2'b01, 4'b0000, 0, 3'b000, 0, 0, 0, 8'h00, 0, 0, 0, 0)); // 0 NOP
    tab.push_back(mk(16'h3600, 1, 5, 1, 2'b01, 4'b0010, 1, 3'b001, 0, 1, 2, 8'h00, 0, 1, 0, 0)); // 1 ADD
    tab.push_back(mk(16'h2C5A, 1, 5, 1, 2'b01, 4'b1000, 1, 3'b000, 1, 3, 0, 8'h5A, 0, 1, 0, 0)); // 2 MVI
    tab.push_back(mk(16'hA040, 1, 3, 1, 2'b10, 4'b0000, 0, 3'b000, 0, 0, 0, 8'h40, 0, 0, 0, 0)); // 3 JMP
    tab.push_back(mk(16'hB0FE, 1, 3, 1, 2'b11, 4'b0000, 0, 3'b000, 0, 0, 0, 8'hFE, 0, 0, 0, 0)); // 4 JR
    tab.push_back(mk(16'h4B00, 1, 5, 1, 2'b01, 4'b0100, 1, 3'b010, 0, 2, 3, 8'h00, 0, 1, 0, 0)); // 5 SUB
    tab.push_back(mk(16'h7133, 1, 5, 1, 2'b01, 4'b0001, 1, 3'b001, 1, 0, 1, 8'h33, 0, 1, 0, 0)); // 6 ADI
    tab.push_back(mk(16'hC000, 1, 3, 1, 2'b01, 4'b0000, 0, 3'b000, 0, 0, 0, 8'h00, 1, 0, 0, 0)); // 7 ILL
    tab.push_back(mk(16'h9E00,16,20, 1, 2'b01, 4'b1000, 1, 3'b110, 0, 3, 2, 8'h00, 0, 1, 0, 0)); // 8 SHR, done on 16th WAIT
    tab.push_back(mk(16'h5500, 1, 5, 1, 2'b01, 4'b0010, 1, 3'b011, 0, 1, 1, 8'h00, 0, 1, 0, 0)); // 9 AND
    tab.push_back(mk(16'hE1FF, 1, 3, 1, 2'b01, 4'b0000, 0, 3'b000, 0, 0, 1, 8'hFF, 1, 0, 0, 0)); // 10 ILL
    tab.push_back(mk(16'h6A00, 1, 5, 1, 2'b01, 4'b0100, 1, 3'b100, 0, 2, 2, 8'h00, 0, 1, 0, 0)); // 11 OR
    tab.push_back(mk(16'h8F0C, 1, 5, 1, 2'b01, 4'b1000, 1, 3'b101, 0, 3, 3, 8'h0C, 0, 1, 0, 0)); // 12 SHL
    tab.push_back(mk(16'h1400, 1, 5, 1, 2'b01, 4'b0010, 1, 3'b000, 0, 1, 0, 8'h00, 0, 1, 0, 0)); // 13 MOV
    tab.push_back(mk(16'h3600, 0,20, 0, 2'b00, 4'b0000, 1, 3'b001, 0, 1, 2, 8'h00, 0, 1, 1, 1)); // 14 watchdog
    tab.push_back(mk(16'h0D12, 1, 3, 1, 2'b01, 4'b0000, 0, 3'b000, 0, 3, 1, 8'h12, 0, 0, 0, 0)); // 15 NOP w/ fields
    tab.push_back(mk(16'hF000, 1, 3, 0, 2'b00, 4'b0000, 0, 3'b000, 0, 0, 0, 8'h00, 0, 0, 1, 0)); // 16 HALT
    tab.push_back(mk(16'h0000, 1, 3, 1, 2'b01, 4'b0000, 0, 3'b000, 0, 0, 0, 8'h00, 0, 0, 0, 0)); // 17 NOP
    tab.push_back(mk(16'h3D00, 1, 5, 1, 2'b01, 4'b1000, 1, 3'b001, 0, 3, 1, 8'h00, 0, 1, 0, 0)); // 18 ADD r3,r1

    // reset held with start high and a HALT word on the bus
    rst = 1'b1; start = 1'b1; ir = 16'hF000;
    @(negedge clk); chk("reset_outputs_a", all_out(), 35'h0);
    @(negedge clk); chk("reset_outputs_b", all_out(), 35'h0);
    rst = 1'b0;

    // program 1: start dropped after the first instruction must not stall it
    for (int i = 0; i <= 14; i++) begin
      run_vec(i);
      if (i == 0) start = 1'b0;
    end

    // program 2: HALT is terminal and ignores start
    rst = 1'b1;
    @(negedge clk);
    chk("reset_clears_sticky", {halted, err_timeout}, 2'b00);
    rst = 1'b0; start = 1'b1;
    run_vec(15);
    run_vec(16);
    seen = 0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      start = c[0];
      @(negedge clk);
      if (en_pc_pulse || en_in || reg_en != 4'b0) seen++;
      if (!halted) bad++;
    end
    chk("halt_no_activity", seen, 0);
    chk("halt_sticky", bad, 0);

    // program 3: asynchronous reset in the middle of WAIT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b1; dp_k = 0; ir = 16'h3600;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (en_in) seen = 1;
    end
    chk("mid_wait_en_in_seen", seen, 1);
    repeat (3) @(negedge clk);
    chk("mid_wait_pre_rd", rd, 2'd1);
    chk("mid_wait_pre_func", alu_func, 3'b001);
    rst = 1'b1;
    #1 chk("mid_wait_async_reset", all_out(), 35'h0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; dp_k = 1; ir = 16'h0000;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (en_pc_pulse || en_in) seen++;
    end
    chk("idle_without_start", seen, 0);
    start = 1'b1;
    run_vec(17);
    run_vec(18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
